sdram_stream_reader: RTL and testbench
======================================

Name: sdram_stream_reader

Overview:
- Streaming prefetch stage between the SDRAM bus and the audio playback path.
- Given a word range, it issues sequential single-word reads on the core-side SDRAM request interface (level request, one-cycle finished pulse) and buffers the returned words in a FIFO.
- It presents the words on a valid/ready stream toward the audio bus, so that SDRAM latency jitter never starves the DAC.
- Used by playback-type cores in place of their own fetch logic.

Parameters:
- DEPTH, 8, FIFO depth in 32-bit words; power of two, minimum 2.
- ADDR_W, 23, SDRAM word address width.
- DATA_W, 32, word width (left sample [31:16], right sample [15:0]).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; latches start_addr/end_addr; ignored unless IDLE.
- start_addr  in  ADDR_W  first word address.
- end_addr  in  ADDR_W  exclusive end address.
- pause  in  1  level; suspends new fetches and output.
- stop  in  1  one-cycle pulse; aborts the stream.
- done  out  1  one-cycle pulse: stream completed or aborted.
- busy  out  1  high in any state other than IDLE.
- sdram_read  out  1  read request level.
- sdram_addr  out  ADDR_W  request address.
- sdram_readdata  in  DATA_W  valid on the sdram_finished cycle.
- sdram_finished  in  1  one-cycle completion pulse.
- audio_valid  out  1  stream valid.
- audio_data  out  DATA_W  FIFO head word.
- audio_ready  in  1  stream ready.

Behaviour:
- Reset (i_rst low, asynchronous): state IDLE; all outputs 0; FIFO pointers and count 0; address registers 0.
- States:
  - IDLE: start with end_addr > start_addr -> FETCH, addr = start_addr. Start with end_addr <= start_addr -> DONE, with no SDRAM access.
  - FETCH:
    - Issue a request when addr != end_reg, count < DEPTH and pause = 0.
    - While requesting, sdram_read = 1 and sdram_addr = addr, both held stable until sdram_finished.
    - On sdram_finished: write sdram_readdata to the FIFO tail, addr += 1, drop sdram_read in the same cycle. The next request may assert on the following cycle, giving one cycle of gap per word.
    - When addr == end_reg with no request outstanding -> DRAIN.
  - DRAIN: no requests; when the FIFO is empty -> DONE.
  - ABORT: entered on stop from FETCH or DRAIN.
    - If a request is outstanding, keep sdram_read high until sdram_finished and discard that word.
    - Then flush the FIFO (count = 0) -> DONE.
  - DONE: done = 1 for exactly one cycle -> IDLE.
- Only one request may be outstanding at a time. Room check is count + outstanding < DEPTH, so no overflow is possible.
- Stream output:
  - audio_valid = (count != 0) && !pause && state in {FETCH, DRAIN}.
  - audio_data = FIFO head; the output is a registered memory read, so it is stable while valid && !ready.
  - A transfer occurs when audio_valid && audio_ready; pop head.
- Simultaneous push and pop in one cycle: count unchanged; both pointers advance.
- Full (count == DEPTH): no request issued; pop still allowed.
- Empty in FETCH: audio_valid = 0. An underrun is not an error.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Address arithmetic is modulo 2^ADDR_W. No wrap occurs within a valid range, because end_addr > start_addr is enforced at start.
- pause:
  - Does not cancel an already-asserted request; that request completes normally and its word is stored.
  - Blocks new requests and forces audio_valid = 0.
- Event priority:
  - stop has priority over pause and over the FETCH -> DRAIN transition.
  - start while busy is ignored.
  - stop in IDLE is ignored.
- Reset mid-transfer: immediate return to IDLE; any in-flight SDRAM read is abandoned. The SDRAM bus is reset by the same reset.

Decomposition:
- Shared package (acappella_pkg): SDRAM address/data width constants and the state enum type {IDLE, FETCH, DRAIN, ABORT, DONE}.
- One sub-module: stream_fifo (synchronous FIFO with push/pop/count/flush, parameterised by DEPTH and DATA_W).
- The FSM and address counter stay in the top module.

Test Plan:
- start 0x000100, end 0x000104, SDRAM model with 3-cycle latency returning data = addr, audio_ready = 1 -> reads issued at 0x100..0x103 in order; audio_data sequence 0x100..0x103; one done pulse after the last transfer.
- audio_ready = 0, range of 20 words, DEPTH = 8 -> exactly 8 requests, then sdram_read stays 0 with count = 8; release ready -> fetching resumes; all 20 words delivered in order, none lost or duplicated.
- start with start_addr = end_addr = 0x5 -> zero SDRAM requests; done pulses 2 cycles after start.
- stop asserted while sdram_read is high -> sdram_read held until sdram_finished; word discarded; FIFO flushed; audio_valid = 0; done pulses once; busy then 0.
- pause held 10 cycles mid-stream -> no new request and audio_valid = 0 throughout; resume -> stream continues at the next address without a gap in data order.
- i_rst pulled low mid-request -> all outputs 0 asynchronously; after release, a new start from 0x0 streams correctly.

Source files
------------

// File: rtl/acappella_pkg.sv
// Shared definitions for the SDRAM streaming blocks.
// Holds the core-side SDRAM word address/data widths and the
// state type of the stream reader controller.
package acappella_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    ABORT,
    DONE
  } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with a registered head word.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write wdata at the tail
//   pop             consume the head word
//   flush           empty the FIFO (pointers and count to zero)
//   rdata           current head word, registered
//   count           number of stored words (0..DEPTH)
//   full            count == DEPTH
// The caller never pushes when full and never pops when empty.
module stream_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q,  count_d;
  logic [DATA_W-1:0] head_q,   head_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Head register tracks mem[rd_ptr_d]; when the word being written lands
    // exactly at the next head slot (FIFO empty or draining to empty), the
    // array is not yet updated, so forward the write data.
    if (push && (wr_ptr_q == rd_ptr_d)) head_d = wdata;
    else                                head_d = mem[rd_ptr_d];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = head_q;
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/sdram_stream_reader.sv
// Streaming prefetch between the core-side SDRAM port and the audio path.
// Reads words [start_addr, end_addr) one at a time, buffers them in a
// FIFO and presents them on a valid/ready stream.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-low reset
//   start, start_addr,
//   end_addr                launch a stream (accepted only when idle)
//   pause                   level: hold off new fetches and output
//   stop                    pulse: abort the running stream
//   done, busy              completion pulse / not-idle status
//   sdram_read, sdram_addr,
//   sdram_readdata,
//   sdram_finished          level-request SDRAM read port
//   audio_valid, audio_data,
//   audio_ready             output stream (left [31:16], right [15:0])
module sdram_stream_reader
  import acappella_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = SDRAM_ADDR_W,
  parameter int DATA_W = SDRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              pause,
  input  logic              stop,
  output logic              done,
  output logic              busy,
  output logic              sdram_read,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_finished,
  output logic              audio_valid,
  output logic [DATA_W-1:0] audio_data,
  input  logic              audio_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [ADDR_W-1:0] end_q,   end_d;
  logic              rd_q,    rd_d;
  logic              done_q,  done_d;
  logic              busy_q,  busy_d;

  logic              fifo_push, fifo_pop, fifo_flush, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic              streaming;

  assign streaming   = (state_q == FETCH) || (state_q == DRAIN);
  assign audio_valid = (fifo_count != '0) && !pause && streaming;
  assign fifo_pop    = audio_valid && audio_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    end_d      = end_q;
    rd_d       = rd_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    // A request is dropped the cycle it completes, whatever the state.
    if (rd_q && sdram_finished) rd_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = start_addr;
          end_d   = end_addr;
          state_d = (end_addr > start_addr) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (rd_q && sdram_finished) begin
          fifo_push = 1'b1;
          addr_d    = addr_q + ADDR_W'(1);
        end
        if (stop) begin
          state_d = ABORT;
        end else if (!rd_q && (addr_q == end_q)) begin
          state_d = DRAIN;
        end else if (!rd_q && !fifo_full && !pause) begin
          // Only asked while nothing is outstanding, so count alone is the
          // room check; the request gap after each word falls out of this.
          rd_d = 1'b1;
        end
      end
      DRAIN: begin
        if (stop)                   state_d = ABORT;
        else if (fifo_count == '0)  state_d = DONE;
      end
      ABORT: begin
        // Let an in-flight read finish on the bus, drop its word, then flush.
        if (!rd_q || sdram_finished) begin
          fifo_flush = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_q == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  stream_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (fifo_push),
    .wdata (sdram_readdata),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (audio_data),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign sdram_read = rd_q;
  assign sdram_addr = addr_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sdram_stream_reader.sv
// Directed bench for sdram_stream_reader with an SDRAM latency model,
// a transaction-level stream model and per-cycle output comparison.
module tb_sdram_stream_reader;

  localparam int DEPTH = 8;
  localparam int AW    = 23;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, pause, stop;
  logic [AW-1:0] start_addr, end_addr;
  logic          done, busy, sdram_read;
  logic [AW-1:0] sdram_addr;
  logic [DW-1:0] sdram_readdata = '0;
  logic          sdram_finished = 1'b0;
  logic          audio_valid;
  logic [DW-1:0] audio_data;
  logic          audio_ready;

  int checks = 0;
  int passes = 0;
  int sd_lat = 3;

  // stream model
  bit            busy_m = 0, streaming = 0, aborted = 0;
  int            fifo_occ = 0, prev_occ = 0;
  logic [AW-1:0] req_next = '0, out_next = '0, end_m = '0;
  int            req_count = 0, xfer_count = 0, done_count = 0;
  bit            prev_read = 0, prev_fin = 0, prev_valid = 0, prev_ready = 0, prev_pause = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;

  sdram_stream_reader #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .pause          (pause),
    .stop           (stop),
    .done           (done),
    .busy           (busy),
    .sdram_read     (sdram_read),
    .sdram_addr     (sdram_addr),
    .sdram_readdata (sdram_readdata),
    .sdram_finished (sdram_finished),
    .audio_valid    (audio_valid),
    .audio_data     (audio_data),
    .audio_ready    (audio_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [DW-1:0] sd_data(input logic [AW-1:0] a);
    return {9'd0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_addr = s; end_addr = e; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string nm);
    int d0;
    d0 = done_count;
    for (int i = 0; i < limit && done_count == d0; i++) cyc();
    chk(nm, 64'(done_count - d0), 64'd1);
  endtask

  // SDRAM: accepts a request level, answers after sd_lat cycles with a
  // one-cycle finished pulse; readdata is junk outside that pulse.
  initial begin : sdram_model
    bit            pend;
    int            lat;
    logic [AW-1:0] a;
    pend = 0; lat = 0; a = '0;
    forever begin
      @(posedge clk); #1;
      sdram_finished = 1'b0;
      sdram_readdata = 32'hDEAD_BEEF;
      if (!rst_n) pend = 0;
      else if (pend) begin
        lat--;
        if (lat == 0) begin
          sdram_finished = 1'b1;
          sdram_readdata = sd_data(a);
          pend = 0;
        end
      end else if (sdram_read) begin
        pend = 1; a = sdram_addr; lat = sd_lat;
      end
    end
  end

  // Per-cycle comparison against the stream model, sampled mid-cycle.
  initial begin : compare
    bit exp_valid;
    int occ_now;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctrl", 64'({done, busy, sdram_read, audio_valid}), 64'd0);
        chk("rst_addr", 64'(sdram_addr), 64'd0);
        chk("rst_data", 64'(audio_data), 64'd0);
        busy_m = 0; streaming = 0; aborted = 0; fifo_occ = 0; prev_occ = 0;
        prev_read = 0; prev_fin = 0; prev_valid = 0; prev_ready = 0; prev_pause = 0;
      end else begin
        occ_now = fifo_occ;
        if (done) begin
          chk("done_owner", 64'(busy_m), 64'd1);
          if (!aborted) chk("done_all_out", 64'(out_next), 64'(end_m));
          busy_m = 0; streaming = 0; done_count++;
        end
        chk("busy", 64'(busy), 64'(busy_m));
        if (prev_read && !prev_fin) begin
          chk("read_held", 64'(sdram_read), 64'd1);
          chk("addr_held", 64'(sdram_addr), 64'(prev_addr));
        end
        if (sdram_read && !prev_read) begin
          req_count++;
          chk("req_allowed", 64'(streaming && !prev_pause && prev_occ < DEPTH && req_next != end_m), 64'd1);
          chk("req_addr", 64'(sdram_addr), 64'(req_next));
        end
        exp_valid = streaming && !pause && fifo_occ != 0;
        chk("audio_valid", 64'(audio_valid), 64'(exp_valid));
        if (prev_valid && !prev_ready && audio_valid)
          chk("data_stable", 64'(audio_data), 64'(prev_data));
        if (exp_valid && audio_valid && audio_ready) begin
          chk("audio_data", 64'(audio_data), 64'(sd_data(out_next)));
          out_next++; xfer_count++; fifo_occ--;
        end
        if (sdram_finished && streaming) begin
          fifo_occ++; req_next++;
          chk("no_overflow", 64'(fifo_occ <= DEPTH), 64'd1);
        end
        if (stop && streaming) begin
          streaming = 0; aborted = 1; fifo_occ = 0;
        end
        if (start && !busy_m) begin
          busy_m = 1; aborted = 0; fifo_occ = 0;
          streaming = (end_addr > start_addr);
          req_next = start_addr; out_next = start_addr; end_m = end_addr;
        end
        prev_read = sdram_read; prev_fin = sdram_finished; prev_addr = sdram_addr;
        prev_valid = audio_valid; prev_ready = audio_ready; prev_data = audio_data;
        prev_pause = pause; prev_occ = occ_now;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin : stim
    int r0, x0, d0;
    rst_n = 1'b1; start = 0; pause = 0; stop = 0; audio_ready = 0;
    start_addr = '0; end_addr = '0;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    chk("reset_ctrl", 64'({done, busy, sdram_read, audio_valid}), 64'd0);
    chk("reset_addr", 64'(sdram_addr), 64'd0);
    chk("reset_data", 64'(audio_data), 64'd0);
    rst_n = 1'b1;
    cyc();

    // basic 4-word stream
    audio_ready = 1; sd_lat = 3; r0 = req_count; x0 = xfer_count;
    do_start(23'h100, 23'h104);
    chk("t1_no_req_yet", 64'(sdram_read), 64'd0);
    cyc();
    chk("t1_first_req", 64'({sdram_read, sdram_addr}), 64'({1'b1, 23'h100}));
    wait_done(200, "t1_done");
    chk("t1_reqs", 64'(req_count - r0), 64'd4);
    chk("t1_words", 64'(xfer_count - x0), 64'd4);
    chk("t1_last", 64'(out_next), 64'h104);

    // back-pressure fills the FIFO, then 20 words drain in order
    audio_ready = 0; r0 = req_count; x0 = xfer_count;
    do_start(23'h2000, 23'h2014);
    repeat (80) cyc();
    chk("t2_reqs_full", 64'(req_count - r0), 64'd8);
    chk("t2_read_idle", 64'(sdram_read), 64'd0);
    chk("t2_valid", 64'(audio_valid), 64'd1);
    chk("t2_head", 64'(audio_data), 64'h2000);
    audio_ready = 1;
    wait_done(400, "t2_done");
    chk("t2_reqs", 64'(req_count - r0), 64'd20);
    chk("t2_words", 64'(xfer_count - x0), 64'd20);
    chk("t2_last", 64'(out_next), 64'h2014);

    // empty range: no access, done two cycles after start
    r0 = req_count;
    start_addr = 23'h5; end_addr = 23'h5; start = 1;
    cyc(); start = 0;
    chk("t3_done_early", 64'({done, busy}), 64'b01);
    cyc();
    chk("t3_done", 64'({done, busy}), 64'b10);
    cyc();
    chk("t3_done_once", 64'(done), 64'd0);
    chk("t3_no_req", 64'(req_count - r0), 64'd0);

    // stop with a read in flight and words buffered
    audio_ready = 0; sd_lat = 5; r0 = req_count; x0 = xfer_count; d0 = done_count;
    do_start(23'h300, 23'h310);
    for (int i = 0; i < 300 && !((req_count - r0) >= 3 && sdram_read); i++) cyc();
    chk("t4_inflight", 64'(sdram_read), 64'd1);
    stop = 1; cyc(); stop = 0;
    chk("t4_held", 64'(sdram_read), 64'd1);
    wait_done(50, "t4_done");
    chk("t4_reqs", 64'(req_count - r0), 64'd3);
    chk("t4_words", 64'(xfer_count - x0), 64'd0);
    chk("t4_after", 64'({audio_valid, busy, sdram_read}), 64'd0);
    audio_ready = 1;
    repeat (3) cyc();
    chk("t4_stay_empty", 64'(audio_valid), 64'd0);

    // pause mid-stream, plus a start that must be ignored while busy
    sd_lat = 2; r0 = req_count; x0 = xfer_count;
    do_start(23'h400, 23'h410);
    for (int i = 0; i < 200 && (xfer_count - x0) < 4; i++) cyc();
    pause = 1; cyc();
    d0 = req_count;
    repeat (10) begin
      chk("t5_pause_valid", 64'(audio_valid), 64'd0);
      cyc();
    end
    chk("t5_pause_noreq", 64'(req_count - d0), 64'd0);
    chk("t5_pause_read", 64'(sdram_read), 64'd0);
    start_addr = 23'h7000; end_addr = 23'h7010; start = 1; pause = 0;
    cyc(); start = 0;
    wait_done(300, "t5_done");
    chk("t5_reqs", 64'(req_count - r0), 64'd16);
    chk("t5_words", 64'(xfer_count - x0), 64'd16);
    chk("t5_last", 64'(out_next), 64'h410);

    // stop while idle does nothing
    d0 = done_count;
    stop = 1; cyc(); stop = 0;
    repeat (3) cyc();
    chk("idle_stop", 64'({busy, 8'(done_count - d0)}), 64'd0);

    // asynchronous reset mid-request, then a clean stream from 0
    sd_lat = 4;
    do_start(23'h500, 23'h508);
    for (int i = 0; i < 50 && !sdram_read; i++) cyc();
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("t6_async_ctrl", 64'({done, busy, sdram_read, audio_valid}), 64'd0);
    chk("t6_async_addr", 64'(sdram_addr), 64'd0);
    chk("t6_async_data", 64'(audio_data), 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    r0 = req_count; x0 = xfer_count;
    do_start(23'h0, 23'h6);
    wait_done(200, "t6_done");
    chk("t6_reqs", 64'(req_count - r0), 64'd6);
    chk("t6_words", 64'(xfer_count - x0), 64'd6);
    chk("t6_last", 64'(out_next), 64'h6);

    repeat (2) cyc();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
